// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART transmitter: register offsets, bit positions,
// TX state encodings and APB response codes.
package apb_uart_pkg;

    // Register word offsets, decoded from PADDR[3:2]
    localparam logic [1:0] REG_CTRL     = 2'h0;
    localparam logic [1:0] REG_BAUD_DIV = 2'h1;
    localparam logic [1:0] REG_TXDATA   = 2'h2;
    localparam logic [1:0] REG_STATUS   = 2'h3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_DONE      = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_START = 2'd1;
    localparam logic [1:0] FSM_DATA  = 2'd2;
    localparam logic [1:0] FSM_STOP  = 2'd3;

    localparam logic APB_RESP_OK  = 1'b0;
    localparam logic APB_RESP_ERR = 1'b1;

endpackage

// File: rtl/apb_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; pushes while full and
// pops while empty are ignored, fullness is judged before any same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_tx.sv
// APB completer that queues bytes in a TX FIFO and serialises them as 8N1 frames
// on TXD, with a status register and a level frame-done interrupt.
module apb_uart_tx
    import apb_uart_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  TXD,
    output logic                  IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          pready_reg;
    logic [1:0]    ctrl_reg;
    logic [15:0]   baud_div;
    logic          done_reg;
    logic          irq_reg;
    logic          txd_reg;
    logic [1:0]    state_reg;
    logic [15:0]   baud_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;

    logic          access;
    logic          complete;
    logic          wr_en;
    logic          rd_en;
    logic [1:0]    reg_sel;
    logic [31:0]   status_word;
    logic [31:0]   rdata_mux;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          bit_end;
    logic          start_ok;
    logic          done_set;
    logic          done_clr;
    logic          unused_ok;

    assign access   = PSEL & PENABLE;
    assign complete = access & pready_reg;
    assign wr_en    = complete & PWRITE;
    assign rd_en    = complete & ~PWRITE;
    assign reg_sel  = PADDR[3:2];

    // One fixed wait state: PREADY rises on the second ACCESS cycle only
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_reg <= 1'b0;
        end else begin
            pready_reg <= access & ~pready_reg;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_reg <= '0;
        end else if (wr_en && reg_sel == REG_CTRL && PSTRB[0]) begin
            ctrl_reg <= PWDATA[1:0];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_baud_lane
        logic [7:0] lane_reg;
        always_ff @(posedge PCLK) begin
            if (PRESET) begin
                lane_reg <= DEFAULT_DIV[gi*8 +: 8];
            end else if (wr_en && reg_sel == REG_BAUD_DIV && PSTRB[gi]) begin
                lane_reg <= PWDATA[gi*8 +: 8];
            end
        end
        assign baud_div[gi*8 +: 8] = lane_reg;
    end

    always_comb begin
        status_word                          = '0;
        status_word[STAT_BUSY]               = (state_reg != FSM_IDLE);
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_EMPTY]              = fifo_empty;
        status_word[STAT_DONE]               = done_reg;
        status_word[STAT_COUNT_LSB +: CW]    = fifo_count;
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_CTRL:     rdata_mux = {30'd0, ctrl_reg};
            REG_BAUD_DIV: rdata_mux = {16'd0, baud_div};
            REG_STATUS:   rdata_mux = status_word;
            default:      rdata_mux = '0;
        endcase
    end

    assign PRDATA    = rd_en ? rdata_mux : '0;
    assign PREADY    = pready_reg;
    assign fifo_push = wr_en & (reg_sel == REG_TXDATA) & PSTRB[0];
    assign PSLVERR   = (fifo_push & fifo_full) ? APB_RESP_ERR : APB_RESP_OK;
    assign done_clr  = wr_en & (reg_sel == REG_STATUS) & PSTRB[0] & PWDATA[STAT_DONE];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .srst  (PRESET),
        .push  (fifo_push),
        .din   (PWDATA[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end  = (baud_cnt_reg == '0);
    assign start_ok = ctrl_reg[CTRL_EN] & ~fifo_empty;
    assign done_set = (state_reg == FSM_STOP) & bit_end;
    // Pop at frame start, either from idle or straight out of a finishing STOP bit
    assign fifo_pop = start_ok & ((state_reg == FSM_IDLE) | done_set);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= FSM_IDLE;
            txd_reg      <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                FSM_IDLE: begin
                    if (fifo_pop) begin
                        state_reg    <= FSM_START;
                        shift_reg    <= fifo_dout;
                        txd_reg      <= 1'b0;
                        baud_cnt_reg <= baud_div;
                    end
                end
                FSM_START: begin
                    if (bit_end) begin
                        state_reg    <= FSM_DATA;
                        txd_reg      <= shift_reg[0];
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg  <= '0;
                        baud_cnt_reg <= baud_div;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                FSM_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= baud_div;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= FSM_STOP;
                            txd_reg   <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            txd_reg     <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                FSM_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            state_reg    <= FSM_START;
                            shift_reg    <= fifo_dout;
                            txd_reg      <= 1'b0;
                            baud_cnt_reg <= baud_div;
                        end else begin
                            state_reg <= FSM_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= FSM_IDLE;
            endcase
        end
    end

    // A DONE set in the same cycle as a W1C wins
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            done_reg <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            if (done_set) begin
                done_reg <= 1'b1;
            end else if (done_clr) begin
                done_reg <= 1'b0;
            end
            irq_reg <= ctrl_reg[CTRL_IRQ_EN] & done_reg;
        end
    end

    assign TXD = txd_reg;
    assign IRQ = irq_reg;

    assign unused_ok = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:16], PSTRB[3:2]};

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: APB register access and handshake timing, with a
// byte scoreboard compared against the serial frames observed on TXD.
module tb_apb_uart_tx;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        TXD;
    logic        IRQ;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];

    always #5 PCLK = ~PCLK;

    apb_uart_tx #(
        .ADDR_WIDTH  (32),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .TXD     (TXD),
        .IRQ     (IRQ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SETUP + 2 ACCESS cycles; returns 1 time unit after the completing edge
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = {28'h0, addr}; PWDATA = wdata; PSTRB = wr ? strb : 4'h0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("pready_access1", PREADY, 1'b0);
        @(posedge PCLK); #1;
        chk("pready_access2", PREADY, 1'b1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
        chk("pready_after", PREADY, 1'b0);
        chk("prdata_idle", PRDATA, 32'h0);
        $display("[%0t] APB %s addr=0x%0h wdata=0x%0h strb=0x%0h rdata=0x%0h err=%0b",
                 $time, wr ? "WR" : "RD", addr, wdata, strb, rdata, err);
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, output logic err);
        logic [31:0] unused_rd;
        apb_xfer(1'b1, addr, wdata, strb, unused_rd, err);
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] rdata);
        logic unused_err;
        apb_xfer(1'b0, addr, 32'h0, 4'h0, rdata, unused_err);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic exp_err);
        logic err;
        apb_write(4'h8, {24'h0, b}, 4'h1, err);
        chk("push_pslverr", err, exp_err);
    endtask

    // Waits for a start bit, then checks every cycle of all 10 bits against the scoreboard
    task automatic check_frame(input int div, input int max_wait, output int waited);
        logic [7:0] b;
        logic [9:0] bits;
        logic       got;
        b = 8'h00;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) b = exp_q.pop_front();
        bits = {1'b1, b, 1'b0};
        waited = 0;
        do begin
            @(posedge PCLK); #1;
            waited++;
        end while (TXD !== 1'b0 && waited < max_wait);
        chk("frame_start", TXD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            got = bits[i];
            for (int c = 0; c <= div; c++) begin
                if (i != 0 || c != 0) begin
                    @(posedge PCLK); #1;
                end
                if (TXD !== bits[i]) got = TXD;
            end
            chk($sformatf("frame_0x%02h_bit%0d", b, i), got, bits[i]);
        end
        $display("[%0t] FRAME byte=0x%02h div=%0d start_wait=%0d", $time, b, div, waited);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          w;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Reset values
        chk("rst_txd", TXD, 1'b1);
        chk("rst_irq", IRQ, 1'b0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        apb_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
        apb_read(4'h4, rd); chk("rst_baud", rd, 32'h1B1);
        apb_read(4'h8, rd); chk("rst_txdata", rd, 32'h0);
        apb_read(4'hC, rd); chk("rst_status", rd, 32'h4);

        // Handshake and CTRL readback
        apb_write(4'h0, 32'h3, 4'hF, err); chk("ctrl_wr_err", err, 1'b0);
        apb_read(4'h0, rd); chk("ctrl_readback", rd, 32'h3);

        // Single frame, latency, DONE and IRQ
        apb_write(4'h4, 32'h3, 4'h3, err);
        apb_read(4'h4, rd); chk("baud_readback", rd, 32'h3);
        push_byte(8'h55, 1'b0); exp_q.push_back(8'h55);
        chk("txd_before_fall", TXD, 1'b1);
        check_frame(3, 50, w);
        chk("txd_fall_latency", w, 1);
        @(posedge PCLK); #1; chk("irq_lag", IRQ, 1'b0);
        @(posedge PCLK); #1; chk("irq_set", IRQ, 1'b1);
        apb_read(4'hC, rd); chk("status_done", rd, 32'hC);
        apb_write(4'hC, 32'h8, 4'h1, err);
        @(posedge PCLK); #1; chk("irq_cleared", IRQ, 1'b0);
        apb_read(4'hC, rd); chk("status_w1c", rd, 32'h4);

        // Back-to-back frames
        apb_write(4'h0, 32'h0, 4'h1, err);
        push_byte(8'hA5, 1'b0); exp_q.push_back(8'hA5);
        push_byte(8'h3C, 1'b0); exp_q.push_back(8'h3C);
        apb_read(4'hC, rd); chk("status_two_queued", rd, 32'h200);
        apb_write(4'h0, 32'h1, 4'h1, err);
        check_frame(3, 20, w);
        check_frame(3, 20, w);
        chk("b2b_gap", w, 1);
        apb_read(4'hC, rd); chk("status_b2b_idle", rd, 32'hC);

        // BAUD_DIV = 0 gives one cycle per bit
        apb_write(4'h4, 32'h0, 4'h3, err);
        push_byte(8'hC3, 1'b0); exp_q.push_back(8'hC3);
        check_frame(0, 20, w);
        chk("div0_latency", w, 1);

        // Overflow and strobe-less write
        apb_write(4'h0, 32'h0, 4'h1, err);
        apb_write(4'hC, 32'h8, 4'h1, err);
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(i), (i == 8) ? 1'b1 : 1'b0);
        end
        apb_read(4'hC, rd); chk("status_full", rd, 32'h802);
        apb_write(4'h0, 32'h3, 4'h0, err); chk("nostrb_err", err, 1'b0);
        apb_read(4'h0, rd); chk("ctrl_nostrb", rd, 32'h0);

        // Reset during DATA bit 3 of the first queued byte (0x00)
        apb_write(4'h4, 32'h3, 4'h3, err);
        apb_write(4'h0, 32'h1, 4'h1, err);
        w = 0;
        do begin
            @(posedge PCLK); #1;
            w++;
        end while (TXD !== 1'b0 && w < 20);
        chk("mid_start", TXD, 1'b0);
        repeat (17) @(posedge PCLK);
        #1;
        chk("mid_bit3", TXD, 1'b0);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("mid_rst_txd", TXD, 1'b1);
        chk("mid_rst_irq", IRQ, 1'b0);
        apb_read(4'hC, rd); chk("mid_rst_status", rd, 32'h4);
        apb_read(4'h4, rd); chk("mid_rst_baud", rd, 32'h1B1);
        apb_read(4'h0, rd); chk("mid_rst_ctrl", rd, 32'h0);
        repeat (10) @(posedge PCLK);
        #1;
        chk("mid_rst_txd_idle", TXD, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_tx.md
Name: apb_uart_tx

Overview:
- APB completer (slave) peripheral: CPU-side APB initiator writes bytes into a TX FIFO; the block serialises them on TXD as 8N1 UART frames.
- Sits on the APB wrapper bus beside the memory and timer slaves, selected by upper-address decode outside this block.
- Provides a status register and a frame-done interrupt.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, >=2).
- DEFAULT_DIV, 16'd433, reset value of BAUD_DIV.

Ports:
- PCLK  in  1  the single clock.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address; only [3:2] decoded.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte-lane write strobes.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error on completing cycle.
- TXD  out  1  serial output, idle high.
- IRQ  out  1  interrupt, level.

Behaviour:
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, TXD=1, IRQ=0, CTRL=0, BAUD_DIV=DEFAULT_DIV, FIFO empty, DONE=0, FSM=IDLE.
- Reset mid-frame: next cycle TXD=1, FIFO flushed, frame abandoned.
- APB handshake, fixed one wait state:
  - PREADY is registered; it is high only on the 2nd ACCESS cycle (PSEL&PENABLE already high for one cycle), then low.
  - Every transfer is SETUP + 2 ACCESS cycles.
- Side effects happen only on the completing cycle (PSEL&PENABLE&PREADY).
- PRDATA and PSLVERR are valid on the completing cycle and 0 otherwise.
- Register map (PADDR[3:2]):
  - 0x0 CTRL, R/W: [0] EN, [1] IRQ_EN; others read 0.
  - 0x4 BAUD_DIV, R/W: [15:0]; each bit lasts BAUD_DIV+1 cycles.
  - 0x8 TXDATA, W: push PWDATA[7:0] if PSTRB[0]; reads return 0.
  - 0xC STATUS, R: [0] BUSY (FSM!=IDLE), [1] FULL, [2] EMPTY, [3] DONE, [11:8] count. Write with PSTRB[0] & PWDATA[3]=1 clears DONE (W1C).
- Writes honour PSTRB per byte lane; lanes beyond a register's width are ignored. PSTRB=0 write is a no-op with no error.
- PSLVERR=1 only for a TXDATA push while FULL; data is dropped and FIFO unchanged.
  - Fullness is sampled before any same-cycle pop, so a push on a full FIFO errors even if a pop occurs that cycle.
- Simultaneous push and pop, not full: both occur, count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when EN & !EMPTY: pop into shift register on the transition; TXD=0 from the next cycle.
  - START -> DATA after BAUD_DIV+1 cycles.
  - DATA sends 8 bits LSB-first, each BAUD_DIV+1 cycles, using a 3-bit bit counter.
  - DATA -> STOP: TXD=1 for BAUD_DIV+1 cycles.
  - At STOP end: DONE set; -> START with a same-cycle pop if EN & !EMPTY (back-to-back, no idle bit), else -> IDLE.
- Push into an empty FIFO while IDLE & EN: TXD falls 2 cycles after the completing APB cycle.
- EN cleared mid-frame: current frame completes, then IDLE; FIFO contents are retained.
- BAUD_DIV written mid-frame: the baud counter reloads from the new value at the next bit boundary.
- Baud counter wraps at 0 then reloads. BAUD_DIV=0 is legal (1 cycle/bit).
- IRQ = IRQ_EN & DONE, registered (one-cycle lag). A W1C and a new DONE set in the same cycle: set wins.

Decomposition:
- Shared package/include apb_uart_pkg:
  - register offset constants;
  - CTRL/STATUS bit indices;
  - FSM state encodings;
  - APB error code.
- One sub-module: sync_fifo, parameterised width/depth, with push/pop/full/empty/count.
- Top holds the APB decode, registers, baud counter and FSM.

Test Plan:
- Reset values: pulse PRESET for 1 cycle; read all four registers -> CTRL=0, BAUD_DIV=0x1B1, STATUS=0x4; TXD=1.
- Handshake timing: write CTRL=0x3 -> PREADY high exactly on the 2nd ACCESS cycle; readback returns 0x3 with PREADY in the same position.
- Single frame: BAUD_DIV=3, push 0x55 -> TXD pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total); DONE=1, then IRQ=1 one cycle later; W1C of 0x8 -> IRQ=0.
- Back-to-back frames: with EN=0, push 0xA5 and 0x3C; set EN=1 -> two contiguous frames with no idle gap; BUSY drops after the second STOP; EMPTY=1.
- Overflow: EN=0, push FIFO_DEPTH+1 bytes -> the last push returns PSLVERR=1; STATUS count=8, FULL=1; strobed writes CTRL with PSTRB=0 leave CTRL unchanged.
- Reset mid-frame: assert PRESET during DATA bit 3 -> next cycle TXD=1, STATUS=0x4, BAUD_DIV=0x1B1.
